// File: rtl/wf_peak_detect.sv
// wf_peak_detect: hysteresis pulse finder on the smoothed waveform stream.
// Each filtered frame is scanned for pulses. For every pulse, the peak amplitude
// and the sample index of that peak are recorded. The events are queued in a
// first-word-fall-through FIFO behind a valid/ready handshake.
// Optional feature macro: WFP_AREA_EN. When it is defined, a per-pulse saturating
// area sum is kept and returned on o_area. When it is undefined, o_area is tied to 0.
module wf_peak_detect #(
    parameter int FRAME_LEN  = 2400,
    parameter int DW         = 16,
    parameter int IDXW       = 12,
    parameter int FIFO_DEPTH = 8,
    parameter int HOLDOFF    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_valid,
    input  logic            i_sof,
    input  logic [DW-1:0]   i_wf,
    input  logic [DW-1:0]   thr_hi,
    input  logic [DW-1:0]   thr_lo,
    output logic            o_valid,
    input  logic            o_ready,
    output logic [IDXW-1:0] o_idx,
    output logic [DW-1:0]   o_amp,
    output logic            o_trunc,
    output logic [27:0]     o_area,
    output logic            o_frame_done,
    output logic [7:0]      o_drop_cnt
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int HCW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        BELOW,
        ABOVE,
        HOLD
    } state_t;

    // ------------------------------------------------------------------
    // Detector state
    // ------------------------------------------------------------------
    state_t          state_q, state_d, eval_st;
    logic [HCW-1:0]  hold_q, hold_d;
    logic [DW-1:0]   peak_q, peak_d;
    logic [IDXW-1:0] pidx_q, pidx_d;
    logic [IDXW-1:0] nidx_q;
    logic [IDXW-1:0] cur_idx;
    logic [DW-1:0]   eff_lo;
    logic            accept;
    logic            last_smp;
    logic            frame_done_q;

    // Event presented to the FIFO this cycle
    logic            push;
    logic            push_trunc;
    logic [IDXW-1:0] push_idx;
    logic [DW-1:0]   push_amp;

`ifdef WFP_AREA_EN
    logic [27:0]     acc_q, acc_d;
    logic [28:0]     acc_sum;
    logic [27:0]     acc_sat;
    logic [27:0]     push_area;
`endif

    // The lower of the two thresholds is used as the release level. This makes
    // sure inverted thresholds still release a pulse.
    assign eff_lo  = (thr_lo < thr_hi) ? thr_lo : thr_hi;

    // Samples are only processed once a frame has been opened by i_sof.
    assign accept  = i_valid && (i_sof || (state_q != IDLE));
    assign cur_idx = i_sof ? '0 : nidx_q;

`ifdef WFP_AREA_EN
    // Saturating running sum of the area with the current sample added.
    always_comb begin
        acc_sum = {1'b0, acc_q} + 29'(i_wf);
        acc_sat = acc_sum[28] ? '1 : acc_sum[27:0];
    end
`endif

    // Next-state and event-generation logic for the hysteresis detector
    always_comb begin
        state_d    = state_q;
        eval_st    = state_q;
        hold_d     = hold_q;
        peak_d     = peak_q;
        pidx_d     = pidx_q;
        push       = 1'b0;
        push_trunc = 1'b0;
        push_idx   = pidx_q;
        push_amp   = peak_q;
        last_smp   = 1'b0;
`ifdef WFP_AREA_EN
        acc_d      = acc_q;
        push_area  = acc_q;
`endif
        if (accept) begin
            // A new frame closes any open pulse as truncated. The current
            // sample then starts fresh from BELOW.
            if (i_sof) begin
                if (state_q == ABOVE) begin
                    push       = 1'b1;
                    push_trunc = 1'b1;
                end
                eval_st = BELOW;
                hold_d  = '0;
            end

            case (eval_st)
                BELOW: begin
                    if (i_wf >= thr_hi) begin
                        state_d = ABOVE;
                        peak_d  = i_wf;
                        pidx_d  = cur_idx;
`ifdef WFP_AREA_EN
                        acc_d   = 28'(i_wf);
`endif
                    end else begin
                        state_d = BELOW;
                    end
                end
                ABOVE: begin
                    if (i_wf < eff_lo) begin
                        push       = 1'b1;
                        push_trunc = 1'b0;
                        if (HOLDOFF > 0) begin
                            state_d = HOLD;
                            hold_d  = HCW'(HOLDOFF);
                        end else begin
                            state_d = BELOW;
                        end
                    end else begin
                        if (i_wf > peak_q) begin
                            peak_d = i_wf;
                            pidx_d = cur_idx;
                        end
`ifdef WFP_AREA_EN
                        acc_d = acc_sat;
`endif
                    end
                end
                HOLD: begin
                    if (hold_q <= HCW'(1)) begin
                        state_d = BELOW;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q - HCW'(1);
                    end
                end
                default: state_d = state_q;
            endcase

            // The last sample of the frame closes a still-open pulse. The
            // event includes this sample. The next frame always starts in BELOW.
            if (cur_idx == LAST_IDX) begin
                last_smp = 1'b1;
                if (state_d == ABOVE) begin
                    push       = 1'b1;
                    push_trunc = 1'b1;
                    push_idx   = pidx_d;
                    push_amp   = peak_d;
`ifdef WFP_AREA_EN
                    push_area  = acc_d;
`endif
                end
                state_d = BELOW;
                hold_d  = '0;
            end
        end
    end

    // State register, sample index counter and frame-done strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            peak_q       <= '0;
            pidx_q       <= '0;
            nidx_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            peak_q       <= peak_d;
            pidx_q       <= pidx_d;
            frame_done_q <= last_smp;
            if (accept) begin
                nidx_q <= last_smp ? '0 : cur_idx + IDXW'(1);
            end
        end
    end

`ifdef WFP_AREA_EN
    // Area accumulator register
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`endif

    assign o_frame_done = frame_done_q;

    // ------------------------------------------------------------------
    // Event FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [AW:0]     wr_ptr, rd_ptr;
    logic            fifo_empty, fifo_full;
    logic            pop, wr_en, drop;
    logic [7:0]      drop_cnt_q;
    logic [IDXW-1:0] mem_idx   [FIFO_DEPTH];
    logic [DW-1:0]   mem_amp   [FIFO_DEPTH];
    logic            mem_trunc [FIFO_DEPTH];
`ifdef WFP_AREA_EN
    logic [27:0]     mem_area  [FIFO_DEPTH];
`endif

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = !fifo_empty && o_ready;
    // When the FIFO is full, a push in the same cycle as a pop still succeeds,
    // because the pop frees the slot on the same edge.
    assign wr_en      = push && (!fifo_full || pop);
    assign drop       = push && fifo_full && !pop;

    // FIFO pointers and saturating drop counter
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (drop && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end
    end

    // FIFO storage writes (payload only, no reset needed)
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_idx[wr_ptr[AW-1:0]]   <= push_idx;
            mem_amp[wr_ptr[AW-1:0]]   <= push_amp;
            mem_trunc[wr_ptr[AW-1:0]] <= push_trunc;
`ifdef WFP_AREA_EN
            mem_area[wr_ptr[AW-1:0]]  <= push_area;
`endif
        end
    end

    // Head outputs are forced to zero while the FIFO is empty. This keeps them
    // clean out of reset and after the FIFO drains.
    assign o_valid    = !fifo_empty;
    assign o_idx      = fifo_empty ? '0 : mem_idx[rd_ptr[AW-1:0]];
    assign o_amp      = fifo_empty ? '0 : mem_amp[rd_ptr[AW-1:0]];
    assign o_trunc    = fifo_empty ? 1'b0 : mem_trunc[rd_ptr[AW-1:0]];
`ifdef WFP_AREA_EN
    assign o_area     = fifo_empty ? '0 : mem_area[rd_ptr[AW-1:0]];
`else
    assign o_area     = '0;
`endif
    assign o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_wf_peak_detect.sv
// tb_wf_peak_detect: directed checks for wf_peak_detect.
// A table of single-pulse frames is followed by hand-written sequences. These
// cover holdoff, sof truncation, frame wrap, overflow, saturation and reset.
module tb_wf_peak_detect;

    localparam int FRAME_LEN = 2400;
    localparam int DW        = 16;
    localparam int IDXW      = 12;
`ifdef WFP_AREA_EN
    localparam bit AREA_ON = 1'b1;
`else
    localparam bit AREA_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            i_valid;
    logic            i_sof;
    logic [DW-1:0]   i_wf;
    logic [DW-1:0]   thr_hi;
    logic [DW-1:0]   thr_lo;
    logic            o_valid;
    logic            o_ready;
    logic [IDXW-1:0] o_idx;
    logic [DW-1:0]   o_amp;
    logic            o_trunc;
    logic [27:0]     o_area;
    logic            o_frame_done;
    logic [7:0]      o_drop_cnt;

    wf_peak_detect #(
        .FRAME_LEN (FRAME_LEN),
        .DW        (DW),
        .IDXW      (IDXW),
        .FIFO_DEPTH(8),
        .HOLDOFF   (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_valid     (i_valid),
        .i_sof       (i_sof),
        .i_wf        (i_wf),
        .thr_hi      (thr_hi),
        .thr_lo      (thr_lo),
        .o_valid     (o_valid),
        .o_ready     (o_ready),
        .o_idx       (o_idx),
        .o_amp       (o_amp),
        .o_trunc     (o_trunc),
        .o_area      (o_area),
        .o_frame_done(o_frame_done),
        .o_drop_cnt  (o_drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDXW-1:0] idx;
        logic [DW-1:0]   amp;
        logic            trunc;
        logic [27:0]     area;
    } ev_t;

    typedef struct {
        logic [DW-1:0]       hi;
        logic [DW-1:0]       lo;
        int                  start;
        logic [0:4][DW-1:0]  v;
        int                  nev;
        int                  eidx;
        int                  eamp;
        logic                etr;
        int                  earea;
        logic                vend;
    } vec_t;

    ev_t         got[$];
    logic [DW-1:0] fr [FRAME_LEN];
    vec_t        tbl [7];
    int          n_chk  = 0;
    int          n_pass = 0;

    // Record every event handed over by the DUT
    always @(negedge clk) begin
        if (!reset && o_valid && o_ready) begin
            got.push_back({o_idx, o_amp, o_trunc, o_area});
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [27:0] exp_area(input int a);
        return AREA_ON ? 28'(a) : 28'd0;
    endfunction

    function automatic vec_t mk(input logic [DW-1:0] hi, input logic [DW-1:0] lo, input int st,
                                input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c,
                                input logic [DW-1:0] d, input logic [DW-1:0] e, input int nev,
                                input int eidx, input int eamp, input logic etr, input int earea,
                                input logic vend);
        vec_t r;
        r.hi = hi; r.lo = lo; r.start = st;
        r.v[0] = a; r.v[1] = b; r.v[2] = c; r.v[3] = d; r.v[4] = e;
        r.nev = nev; r.eidx = eidx; r.eamp = eamp; r.etr = etr; r.earea = earea; r.vend = vend;
        return r;
    endfunction

    // Compare recorded event n against the expected fields
    task automatic cmp_ev(input string tag, input int n, input int eidx, input int eamp,
                          input logic etr, input int earea);
        if (got.size() > n) begin
            chk({tag, "_idx"}, 32'(got[n].idx), 32'(eidx));
            chk({tag, "_amp"}, 32'(got[n].amp), 32'(eamp));
            chk({tag, "_trunc"}, 32'(got[n].trunc), 32'(etr));
            chk({tag, "_area"}, 32'(got[n].area), 32'(exp_area(earea)));
        end else begin
            chk({tag, "_present"}, 32'(got.size()), 32'(n + 1));
        end
    endtask

    task automatic step(input logic v, input logic s, input logic [DW-1:0] w);
        i_valid = v; i_sof = s; i_wf = w;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
    endtask

    task automatic clear_frame();
        for (int i = 0; i < FRAME_LEN; i++) fr[i] = '0;
    endtask

    task automatic run_frame();
        for (int i = 0; i < FRAME_LEN; i++) step(1'b1, i == 0, fr[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = mk(1000, 800,  100, 900, 1200, 1500, 1300, 700, 1, 102, 1500, 0, 4000, 0);
        tbl[1] = mk( 500, 900,  200, 600,  700,  700,  400,   0, 1, 201,  700, 0, 2000, 0);
        tbl[2] = mk(1000, 800, 2395, 1100, 1200, 1300, 1250, 1100, 1, 2397, 1300, 1, 5950, 1);
        tbl[3] = mk(1000, 800,   50, 1000, 999,  800,  799,   0, 1,  50, 1000, 0, 2799, 0);
        tbl[4] = mk(1000, 800, 2395,    0,   0,    0,    0, 1234, 1, 2399, 1234, 1, 1234, 1);
        tbl[5] = mk(1000, 800, 2395,    0,   0,    0, 1500,  100, 1, 2398, 1500, 0, 1500, 1);
        tbl[6] = mk(1000, 800,  300,  999, 999,  999,    0,   0, 0,   0,    0, 0,    0, 0);

        reset = 1'b1; o_ready = 1'b1; thr_hi = 16'd1000; thr_lo = 16'd800;
        idle(2);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_idx", 32'(o_idx), 0);
        chk("rst_amp", 32'(o_amp), 0);
        chk("rst_trunc", 32'(o_trunc), 0);
        chk("rst_area", 32'(o_area), 0);
        chk("rst_fdone", 32'(o_frame_done), 0);
        chk("rst_drop", 32'(o_drop_cnt), 0);
        reset = 1'b0;
        // Samples before the first sof must be ignored
        step(1'b1, 1'b0, 16'd2000); step(1'b1, 1'b0, 16'd0);
        idle(2);
        chk("pre_sof_ignored", 32'(got.size()), 0);

        // Table of single-pulse frames
        foreach (tbl[n]) begin
            thr_hi = tbl[n].hi; thr_lo = tbl[n].lo;
            clear_frame();
            for (int k = 0; k < 5; k++) fr[tbl[n].start + k] = tbl[n].v[k];
            got.delete();
            run_frame();
            chk($sformatf("v%0d_fdone", n), 32'(o_frame_done), 1);
            chk($sformatf("v%0d_vend", n), 32'(o_valid), 32'(tbl[n].vend));
            idle(1);
            chk($sformatf("v%0d_fdone_off", n), 32'(o_frame_done), 0);
            idle(3);
            chk($sformatf("v%0d_nev", n), 32'(got.size()), 32'(tbl[n].nev));
            if (tbl[n].nev > 0)
                cmp_ev($sformatf("v%0d", n), 0, tbl[n].eidx, tbl[n].eamp, tbl[n].etr, tbl[n].earea);
        end

        // Holdoff and one-cycle event latency
        thr_hi = 16'd1000; thr_lo = 16'd800;
        clear_frame();
        fr[100] = 900; fr[101] = 1200; fr[102] = 1500; fr[103] = 1300; fr[104] = 700;
        fr[106] = 1100; fr[109] = 1100;
        got.delete();
        for (int i = 0; i < FRAME_LEN; i++) begin
            step(1'b1, i == 0, fr[i]);
            if (i == 103) chk("lat_pre_valid", 32'(o_valid), 0);
            if (i == 104) begin
                chk("lat_post_valid", 32'(o_valid), 1);
                chk("lat_post_idx", 32'(o_idx), 102);
            end
        end
        idle(3);
        chk("hold_nev", 32'(got.size()), 2);
        cmp_ev("hold_e0", 0, 102, 1500, 0, 4000);
        cmp_ev("hold_e1", 1, 109, 1100, 0, 1100);

        // Truncation at frame end, then wrap without sof starts in BELOW
        clear_frame();
        fr[2396] = 1100; fr[2397] = 1100; fr[2398] = 1100; fr[2399] = 1100;
        got.delete();
        run_frame();
        chk("wrap_fdone", 32'(o_frame_done), 1);
        chk("wrap_trunc_valid", 32'(o_valid), 1);
        step(1'b1, 1'b0, 16'd900);
        step(1'b1, 1'b0, 16'd0);
        step(1'b1, 1'b0, 16'd1100);
        step(1'b1, 1'b0, 16'd0);
        idle(3);
        chk("wrap_nev", 32'(got.size()), 2);
        cmp_ev("wrap_e0", 0, 2396, 1100, 1, 4400);
        cmp_ev("wrap_e1", 1, 2, 1100, 0, 1100);

        // New sof while ABOVE truncates the open pulse; sof sample arms at index 0
        clear_frame();
        fr[500] = 1300; fr[501] = 1400;
        got.delete();
        for (int i = 0; i < 502; i++) step(1'b1, i == 0, fr[i]);
        step(1'b1, 1'b1, 16'd1200);
        step(1'b1, 1'b0, 16'd0);
        idle(3);
        chk("sof_nev", 32'(got.size()), 2);
        cmp_ev("sof_e0", 0, 501, 1400, 1, 2700);
        cmp_ev("sof_e1", 1, 0, 1200, 0, 1200);

        // Overflow: 10 pulses with o_ready low, then a push/pop on a full FIFO
        clear_frame();
        for (int k = 0; k < 10; k++) fr[100 + 20 * k] = 16'(2000 + k);
        fr[400] = 3000;
        got.delete();
        for (int i = 0; i < FRAME_LEN; i++) begin
            o_ready = (i == 401);
            step(1'b1, i == 0, fr[i]);
            if (i == 290) begin
                chk("ovf_drop2", 32'(o_drop_cnt), 2);
                chk("ovf_head_idx", 32'(o_idx), 100);
                chk("ovf_head_amp", 32'(o_amp), 2000);
            end
            if (i == 350) chk("ovf_head_stable", 32'(o_idx), 100);
            if (i == 402) begin
                chk("ovf_pushpop_drop", 32'(o_drop_cnt), 2);
                chk("ovf_head_next", 32'(o_idx), 120);
            end
        end
        o_ready = 1'b1;
        idle(12);
        chk("ovf_nev", 32'(got.size()), 9);
        for (int k = 0; k < 8; k++)
            cmp_ev($sformatf("ovf_e%0d", k), k, 100 + 20 * k, 2000 + k, 0, 2000 + k);
        cmp_ev("ovf_e8", 8, 400, 3000, 0, 3000);
        chk("ovf_drop_end", 32'(o_drop_cnt), 2);
        chk("ovf_empty", 32'(o_valid), 0);

        // Drop counter saturation
        clear_frame();
        for (int m = 0; m < 300; m++) fr[8 * m] = 1500;
        got.delete();
        o_ready = 1'b0;
        run_frame();
        chk("sat_drop", 32'(o_drop_cnt), 255);
        o_ready = 1'b1;
        idle(10);
        chk("sat_nev", 32'(got.size()), 8);
        cmp_ev("sat_first", 0, 0, 1500, 0, 1500);
        cmp_ev("sat_last", 7, 56, 1500, 0, 1500);

        // Reset mid-pulse with an event queued
        clear_frame();
        fr[100] = 1500;
        for (int i = 1498; i <= 1502; i++) fr[i] = 1200;
        fr[1550] = 1300;
        got.delete();
        o_ready = 1'b0;
        for (int i = 0; i < 1600; i++) begin
            reset = (i == 1500);
            step(1'b1, i == 0, fr[i]);
            if (i == 1500) begin
                chk("mid_rst_valid", 32'(o_valid), 0);
                chk("mid_rst_idx", 32'(o_idx), 0);
                chk("mid_rst_amp", 32'(o_amp), 0);
                chk("mid_rst_trunc", 32'(o_trunc), 0);
                chk("mid_rst_area", 32'(o_area), 0);
                chk("mid_rst_fdone", 32'(o_frame_done), 0);
                chk("mid_rst_drop", 32'(o_drop_cnt), 0);
            end
        end
        reset = 1'b0;
        o_ready = 1'b1;
        idle(3);
        chk("post_rst_ignored", 32'(got.size()), 0);
        clear_frame();
        fr[10] = 1100;
        for (int i = 0; i < 20; i++) step(1'b1, i == 0, fr[i]);
        idle(3);
        chk("post_rst_nev", 32'(got.size()), 1);
        cmp_ev("post_rst_e0", 0, 10, 1100, 0, 1100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
